// File: rtl/gardner_ted_if.sv
// I/Q sample and timing-error bundle for gardner_ted_core.
// master drives samples in; slave (the detector) returns the error and primed status.
interface gardner_ted_if #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned OUT_WIDTH = 16
);
   logic                        in_valid;
   logic signed [WIDTH-1:0]     I;
   logic signed [WIDTH-1:0]     Q;
   logic                        error_valid;
   logic signed [OUT_WIDTH-1:0] error_n;
   logic                        primed;

   modport master (
      output in_valid, I, Q,
      input  error_valid, error_n, primed
   );

   modport slave (
      input  in_valid, I, Q,
      output error_valid, error_n, primed
   );
endinterface

// File: rtl/gardner_ted_core.sv
// Gardner timing-error detector with SPS/2 and SPS sample delay lines and a 3-stage error pipeline.
// Define GARDNER_ERR_SAT_EN to saturate the narrowed error instead of wrapping it.
module gardner_ted_core #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned SPS       = 32,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned SHIFT     = 16
) (
   input  logic         clk_32M768,
   input  logic         rst,
   gardner_ted_if.slave bus
);
   localparam int unsigned AW = $clog2(SPS);
   localparam int unsigned DW = WIDTH + 1;
   localparam int unsigned PW = 2 * WIDTH + 1;
   localparam int unsigned SW = 2 * WIDTH + 2;
   localparam logic [AW-1:0] HALF = AW'(SPS / 2);
   localparam logic [AW:0]   FULL = (AW + 1)'(SPS);

   // Stale RAM contents never reach the output: results are gated by primed.
   logic signed [WIDTH-1:0] buf_i [SPS];
   logic signed [WIDTH-1:0] buf_q [SPS];

   logic [AW-1:0]           wptr_q;
   logic [AW:0]             fill_q;
   logic                    primed;

   logic signed [WIDTH-1:0] late_i, late_q, mid_i, mid_q;
   logic signed [DW-1:0]    diff_i_d, diff_q_d, diff_i_q, diff_q_q;
   logic signed [WIDTH-1:0] mid_i_q, mid_q_q;
   logic signed [PW-1:0]    prod_i_d, prod_q_d, prod_i_q, prod_q_q;
   logic signed [SW-1:0]    sum_sh;
   logic signed [OUT_WIDTH-1:0] err_d, err_q;
   logic                    v1_q, v2_q, ev_q;

   assign primed = (fill_q == FULL);

   always_comb begin
      late_i   = buf_i[wptr_q];
      late_q   = buf_q[wptr_q];
      mid_i    = buf_i[wptr_q - HALF];
      mid_q    = buf_q[wptr_q - HALF];
      diff_i_d = DW'(bus.I) - DW'(late_i);
      diff_q_d = DW'(bus.Q) - DW'(late_q);
      prod_i_d = PW'(mid_i_q) * PW'(diff_i_q);
      prod_q_d = PW'(mid_q_q) * PW'(diff_q_q);
      sum_sh   = (SW'(prod_i_q) + SW'(prod_q_q)) >>> SHIFT;
   end

`ifdef GARDNER_ERR_SAT_EN
   localparam logic signed [SW-1:0] SAT_MAX =
      {{(SW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      err_d = OUT_WIDTH'(sum_sh);
      if (sum_sh > SAT_MAX) begin
         err_d = OUT_WIDTH'(SAT_MAX);
      end else if (sum_sh < SAT_MIN) begin
         err_d = OUT_WIDTH'(SAT_MIN);
      end
   end
`else
   always_comb begin
      err_d = OUT_WIDTH'(sum_sh);
   end
`endif

   // Datapath registers: no reset needed, validity travels in v1/v2/ev.
   always_ff @(posedge clk_32M768) begin
      if (bus.in_valid) begin
         buf_i[wptr_q] <= bus.I;
         buf_q[wptr_q] <= bus.Q;
      end
      diff_i_q <= diff_i_d;
      diff_q_q <= diff_q_d;
      mid_i_q  <= mid_i;
      mid_q_q  <= mid_q;
      prod_i_q <= prod_i_d;
      prod_q_q <= prod_q_d;
   end

   always_ff @(posedge clk_32M768) begin
      if (rst) begin
         wptr_q <= '0;
         fill_q <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         ev_q   <= 1'b0;
         err_q  <= '0;
      end else begin
         if (bus.in_valid) begin
            wptr_q <= wptr_q + AW'(1);
            if (fill_q != FULL) begin
               fill_q <= fill_q + (AW + 1)'(1);
            end
         end
         // primed before this sample's accept: the first result needs a full SPS of history.
         v1_q <= bus.in_valid & primed;
         v2_q <= v1_q;
         ev_q <= v2_q;
         if (v2_q) begin
            err_q <= err_d;
         end
      end
   end

   assign bus.error_valid = ev_q;
   assign bus.error_n     = err_q;
   assign bus.primed      = primed;
endmodule

// File: tb/tb_gardner_ted_core.sv
// Directed bench for gardner_ted_core: table of per-cycle vectors plus hand-written multi-cycle sequences.
// A second instance with SHIFT=0 exercises the narrowing / saturation path.
module tb_gardner_ted_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gardner_ted_if #(.WIDTH(16), .OUT_WIDTH(16)) if16 ();
   gardner_ted_if #(.WIDTH(16), .OUT_WIDTH(16)) if0 ();

   gardner_ted_core #(.WIDTH(16), .SPS(32), .OUT_WIDTH(16), .SHIFT(16)) dut (
      .clk_32M768 (clk),
      .rst        (rst),
      .bus        (if16.slave)
   );

   gardner_ted_core #(.WIDTH(16), .SPS(32), .OUT_WIDTH(16), .SHIFT(0)) dut0 (
      .clk_32M768 (clk),
      .rst        (rst),
      .bus        (if0.slave)
   );

   typedef struct {
      logic               rst;
      logic               vld;
      logic signed [15:0] i;
      logic signed [15:0] q;
      logic               exp_valid;
      logic signed [15:0] exp_err;
      logic               exp_primed;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Bench-side expectation state for the sequence checks.
   int                 mfill = 0;
   logic               pv [3];
   logic signed [15:0] pe [3];
   logic signed [15:0] mlast = '0;

   task automatic chk_bit(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
      end
   endtask

   task automatic chk_val(input string name, input logic signed [15:0] got,
                          input logic signed [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic signed [15:0] i,
                        input logic signed [15:0] q);
      @(negedge clk);
      rst          = r;
      if16.in_valid = v;
      if16.I        = i;
      if16.Q        = q;
      if0.in_valid  = v;
      if0.I         = i;
      if0.Q         = q;
      @(posedge clk);
      #1;
   endtask

   // One cycle with the bench's own fill / latency model; sel picks the instance checked.
   task automatic mtick(input bit sel, input logic r, input logic v,
                        input logic signed [15:0] i, input logic signed [15:0] q,
                        input logic signed [15:0] ee);
      logic ev;
      ev = v && !r && (mfill >= 32);
      drive(r, v, i, q);
      if (r) mfill = 0;
      else if (v && mfill < 32) mfill++;
      if (r) begin
         pv = '{1'b0, 1'b0, 1'b0};
         mlast = '0;
      end else begin
         pv[2] = pv[1]; pe[2] = pe[1];
         pv[1] = pv[0]; pe[1] = pe[0];
         pv[0] = ev;    pe[0] = ee;
         if (pv[2]) mlast = pe[2];
      end
      if (sel) begin
         chk_bit("seq_valid0", if0.error_valid, pv[2]);
         chk_val("seq_err0", if0.error_n, mlast);
         chk_bit("seq_primed0", if0.primed, mfill >= 32);
      end else begin
         chk_bit("seq_valid", if16.error_valid, pv[2]);
         chk_val("seq_err", if16.error_n, mlast);
         chk_bit("seq_primed", if16.primed, mfill >= 32);
      end
   endtask

   function automatic vec_t mk(logic r, logic v, logic signed [15:0] i, logic signed [15:0] q,
                               logic ev, logic signed [15:0] ee, logic ep);
      vec_t t;
      t.rst = r; t.vld = v; t.i = i; t.q = q;
      t.exp_valid = ev; t.exp_err = ee; t.exp_primed = ep;
      return t;
   endfunction

   initial begin
      logic signed [15:0] s;
      logic signed [15:0] sat_exp;
      pv = '{1'b0, 1'b0, 1'b0};
      pe = '{16'sd0, 16'sd0, 16'sd0};
      if16.in_valid = 1'b0; if16.I = '0; if16.Q = '0;
      if0.in_valid  = 1'b0; if0.I  = '0; if0.Q  = '0;

      // Flat I=Q=100: primed after sample 32, one zero result 3 cycles after sample 33.
      tbl.push_back(mk(1'b1, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0));
      for (int r = 0; r < 33; r++)
         tbl.push_back(mk(1'b0, 1'b1, 16'sd100, 16'sd100, 1'b0, 16'sd0, r >= 31));
      tbl.push_back(mk(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1, 16'sd0, 1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b1));
      // 31 samples of I=0x4000: never primed, never valid.
      tbl.push_back(mk(1'b1, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0));
      for (int r = 0; r < 31; r++)
         tbl.push_back(mk(1'b0, 1'b1, 16'sh4000, 16'sd0, 1'b0, 16'sd0, 1'b0));
      for (int r = 0; r < 4; r++)
         tbl.push_back(mk(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, 16'sd0, 1'b0));

      for (int n = 0; n < tbl.size(); n++) begin
         drive(tbl[n].rst, tbl[n].vld, tbl[n].i, tbl[n].q);
         chk_bit("tbl_valid", if16.error_valid, tbl[n].exp_valid);
         chk_bit("tbl_primed", if16.primed, tbl[n].exp_primed);
         if (tbl[n].exp_valid || tbl[n].rst)
            chk_val("tbl_err", if16.error_n, tbl[n].exp_err);
      end

      // Ramp I=k*64 back-to-back: e = (k-16)*64 * 2048, >>>16 gives (k-16)*2.
      mtick(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      for (int k = 0; k < 64; k++)
         mtick(1'b0, 1'b0, 1'b1, 16'(k * 64), 16'sd0, 16'((k - 16) * 2));
      for (int k = 0; k < 3; k++) mtick(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);

      // Same ramp with in_valid toggling 1-0: identical results every other cycle.
      mtick(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      for (int k = 0; k < 64; k++) begin
         mtick(1'b0, 1'b0, 1'b1, 16'(k * 64), 16'sd0, 16'((k - 16) * 2));
         mtick(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      end
      for (int k = 0; k < 3; k++) mtick(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);

      // Reset with two results in flight, then a fresh 33-sample ramp.
      mtick(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      for (int k = 0; k < 40; k++)
         mtick(1'b0, 1'b0, 1'b1, 16'(k * 64), 16'sd0, 16'((k - 16) * 2));
      mtick(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      for (int k = 0; k < 3; k++) mtick(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      for (int k = 0; k < 33; k++)
         mtick(1'b0, 1'b0, 1'b1, 16'(k * 64), 16'sd0, 16'((k - 16) * 2));
      for (int k = 0; k < 3; k++) mtick(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);

      // SHIFT=0 overflow: mid +32767, newest +32767, late -32768 on both rails.
`ifdef GARDNER_ERR_SAT_EN
      sat_exp = 16'sd32767;
`else
      sat_exp = 16'sd2;
`endif
      mtick(1'b1, 1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      for (int k = 0; k < 33; k++) begin
         if (k == 0) s = -16'sd32768;
         else if (k == 16 || k == 32) s = 16'sd32767;
         else s = 16'sd0;
         mtick(1'b1, 1'b0, 1'b1, s, s, sat_exp);
      end
      for (int k = 0; k < 3; k++) mtick(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
